// File: rtl/apogeo_pkg.sv
// Shared types for the banked cache data store.
// Build option: OUTPUT_REG_EN adds an output register stage (read latency 2).
package apogeo_pkg;

  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] data_word_t;

  typedef enum logic {
    IDLE,
    FILL
  } fill_state_t;

endpackage

// File: rtl/data_bank.sv
// One word-wide bank of the data store, byte-writable,
// with a registered read port independent of the write port.
module data_bank #(
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   waddr_i,
  input  logic [WORD_WIDTH/8-1:0] be_i,
  input  logic [WORD_WIDTH-1:0]   wdata_i,
  input  logic                    re_i,
  input  logic [ADDR_WIDTH-1:0]   raddr_i,
  output logic [WORD_WIDTH-1:0]   rdata_o
);

  localparam int BYTE_NUM = WORD_WIDTH / 8;

  logic [WORD_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Same-address read returns the old word; the top merges new bytes.
  always_ff @(posedge clk_i) begin
    if (re_i)
      rdata_o <= mem[raddr_i];
    for (int b = 0; b < BYTE_NUM; b++) begin
      if (we_i && be_i[b])
        mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
    end
  end

endmodule

// File: rtl/cache_data_array.sv
// Banked cache data store with line refill FSM and write-first forwarding.
// Build option: OUTPUT_REG_EN adds an output register stage (read latency 2).
module cache_data_array
  import apogeo_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int WORD_WIDTH   = DATA_W,
  parameter int BANK_ADDRESS = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    write_i,
  input  logic [BANK_ADDRESS-1:0] write_bank_i,
  input  logic [ADDR_WIDTH-1:0]   write_address_i,
  input  logic [WORD_WIDTH/8-1:0] byte_write_i,
  input  logic [WORD_WIDTH-1:0]   write_data_i,
  input  logic                    fill_start_i,
  input  logic [ADDR_WIDTH-1:0]   fill_address_i,
  input  logic                    fill_valid_i,
  input  logic [WORD_WIDTH-1:0]   fill_data_i,
  output logic                    fill_done_o,
  output logic                    busy_o,
  input  logic                    read_i,
  input  logic [BANK_ADDRESS-1:0] read_bank_i,
  input  logic [ADDR_WIDTH-1:0]   read_address_i,
  output logic                    read_valid_o,
  output logic [WORD_WIDTH-1:0]   read_data_o
);

  localparam int BYTE_NUM    = WORD_WIDTH / 8;
  localparam int BANK_NUMBER = 2**BANK_ADDRESS;
  localparam logic [BANK_ADDRESS-1:0] LAST_BEAT =
    BANK_ADDRESS'(BANK_NUMBER - 1);

  fill_state_t             state_q;
  logic [BANK_ADDRESS-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0]   fill_addr_q;
  logic                    busy_q;
  logic                    done_q;

  logic                    cpu_wr;
  logic                    cpu_rd;
  logic                    fill_wr;
  logic                    wr_en;
  logic                    coll;
  logic [BANK_ADDRESS-1:0] wr_bank;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [BYTE_NUM-1:0]     wr_be;
  logic [WORD_WIDTH-1:0]   wr_data;
  logic [BANK_NUMBER-1:0]  we_oh;
  logic [BANK_NUMBER-1:0]  re_oh;
  logic [WORD_WIDTH-1:0]   bank_rdata [BANK_NUMBER];

  assign cpu_wr  = write_i & ~busy_q;
  assign cpu_rd  = read_i & ~busy_q;
  assign fill_wr = (state_q == FILL) & fill_valid_i;
  assign wr_en   = cpu_wr | fill_wr;

  assign wr_bank = fill_wr ? cnt_q : write_bank_i;
  assign wr_addr = fill_wr ? fill_addr_q : write_address_i;
  assign wr_be   = fill_wr ? '1 : byte_write_i;
  assign wr_data = fill_wr ? fill_data_i : write_data_i;

  assign we_oh = wr_en ? (BANK_NUMBER'(1) << wr_bank) : '0;
  assign re_oh = cpu_rd ? (BANK_NUMBER'(1) << read_bank_i) : '0;

  assign coll = cpu_wr & cpu_rd
              & (write_bank_i == read_bank_i)
              & (write_address_i == read_address_i);

  for (genvar g = 0; g < BANK_NUMBER; g++) begin : g_bank
    data_bank #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .WORD_WIDTH (WORD_WIDTH)
    ) u_bank (
      .clk_i   (clk_i),
      .we_i    (we_oh[g]),
      .waddr_i (wr_addr),
      .be_i    (wr_be),
      .wdata_i (wr_data),
      .re_i    (re_oh[g]),
      .raddr_i (read_address_i),
      .rdata_o (bank_rdata[g])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fill_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (fill_start_i) begin
            fill_addr_q <= fill_address_i;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            state_q     <= FILL;
          end
        end
        FILL: begin
          if (fill_valid_i) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_BEAT) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign fill_done_o = done_q;

  logic                    rvalid_q;
  logic [BANK_ADDRESS-1:0] rbank_q;
  logic [BYTE_NUM-1:0]     fwd_be_q;
  logic [WORD_WIDTH-1:0]   fwd_data_q;
  logic [WORD_WIDTH-1:0]   hold_q;
  logic [WORD_WIDTH-1:0]   raw;
  logic [WORD_WIDTH-1:0]   merged;
  logic [WORD_WIDTH-1:0]   stage1_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q   <= 1'b0;
      rbank_q    <= '0;
      fwd_be_q   <= '0;
      fwd_data_q <= '0;
    end else begin
      rvalid_q <= cpu_rd;
      if (cpu_rd) begin
        rbank_q    <= read_bank_i;
        fwd_be_q   <= coll ? byte_write_i : '0;
        fwd_data_q <= write_data_i;
      end
    end
  end

  always_comb begin
    raw    = bank_rdata[rbank_q];
    merged = raw;
    for (int b = 0; b < BYTE_NUM; b++) begin
      if (fwd_be_q[b])
        merged[b*8 +: 8] = fwd_data_q[b*8 +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      hold_q <= '0;
    else if (rvalid_q)
      hold_q <= merged;
  end

  assign stage1_data = rvalid_q ? merged : hold_q;

`ifdef OUTPUT_REG_EN
  logic                  out_valid_q;
  logic [WORD_WIDTH-1:0] out_data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= rvalid_q;
      out_data_q  <= stage1_data;
    end
  end

  assign read_valid_o = out_valid_q;
  assign read_data_o  = out_data_q;
`else
  assign read_valid_o = rvalid_q;
  assign read_data_o  = stage1_data;
`endif

endmodule

// File: tb/tb_cache_data_array.sv
// Directed self-checking bench for cache_data_array.
// Build option: OUTPUT_REG_EN selects read latency 2.
module tb_cache_data_array;

`ifdef OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        write_i = 1'b0;
  logic [1:0]  write_bank_i = '0;
  logic [7:0]  write_address_i = '0;
  logic [3:0]  byte_write_i = '0;
  logic [31:0] write_data_i = '0;
  logic        fill_start_i = 1'b0;
  logic [7:0]  fill_address_i = '0;
  logic        fill_valid_i = 1'b0;
  logic [31:0] fill_data_i = '0;
  logic        fill_done_o;
  logic        busy_o;
  logic        read_i = 1'b0;
  logic [1:0]  read_bank_i = '0;
  logic [7:0]  read_address_i = '0;
  logic        read_valid_o;
  logic [31:0] read_data_o;

  int total = 0;
  int bad = 0;

  cache_data_array dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .write_i         (write_i),
    .write_bank_i    (write_bank_i),
    .write_address_i (write_address_i),
    .byte_write_i    (byte_write_i),
    .write_data_i    (write_data_i),
    .fill_start_i    (fill_start_i),
    .fill_address_i  (fill_address_i),
    .fill_valid_i    (fill_valid_i),
    .fill_data_i     (fill_data_i),
    .fill_done_o     (fill_done_o),
    .busy_o          (busy_o),
    .read_i          (read_i),
    .read_bank_i     (read_bank_i),
    .read_address_i  (read_address_i),
    .read_valid_o    (read_valid_o),
    .read_data_o     (read_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_write(input logic [1:0] bank, input logic [7:0] idx,
                          input logic [3:0] be, input logic [31:0] data);
    write_i = 1'b1;
    write_bank_i = bank;
    write_address_i = idx;
    byte_write_i = be;
    write_data_i = data;
    tick();
    write_i = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] bank, input logic [7:0] idx,
                         output logic v, output logic [31:0] d);
    read_i = 1'b1;
    read_bank_i = bank;
    read_address_i = idx;
    tick();
    read_i = 1'b0;
    repeat (LAT - 1) tick();
    v = read_valid_o;
    d = read_data_o;
  endtask

  task automatic beat(input logic [31:0] data);
    fill_valid_i = 1'b1;
    fill_data_i = data;
    tick();
    fill_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    total += 4;
    if (read_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid got=%b want=0", read_valid_o);
    end
    if (read_data_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_data got=%h want=0", read_data_o);
    end
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy got=%b want=0", busy_o);
    end
    if (fill_done_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_done got=%b want=0", fill_done_o);
    end
  endtask

  task automatic test_read_latency();
    logic v;
    logic [31:0] d;
    do_write(2'd2, 8'd5, 4'hF, 32'hDEADBEEF);
    read_i = 1'b1;
    read_bank_i = 2'd2;
    read_address_i = 8'd5;
    tick();
    read_i = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      total++;
      if (read_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL lat_early got=%b want=0", read_valid_o);
      end
      tick();
    end
    v = read_valid_o;
    d = read_data_o;
    total += 2;
    if (v !== 1'b1) begin
      bad++;
      $display("FAIL lat_valid got=%b want=1", v);
    end
    if (d !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL lat_data got=%h want=deadbeef", d);
    end
    tick();
    total += 2;
    if (read_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL lat_drop got=%b want=0", read_valid_o);
    end
    if (read_data_o !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL lat_hold got=%h want=deadbeef", read_data_o);
    end
  endtask

  task automatic test_forward();
    logic v;
    logic [31:0] d;
    do_write(2'd1, 8'd9, 4'hF, 32'h11223344);
    write_i = 1'b1;
    write_bank_i = 2'd1;
    write_address_i = 8'd9;
    byte_write_i = 4'b0101;
    write_data_i = 32'hAABBCCDD;
    read_i = 1'b1;
    read_bank_i = 2'd1;
    read_address_i = 8'd9;
    tick();
    write_i = 1'b0;
    read_i = 1'b0;
    repeat (LAT - 1) tick();
    total++;
    if (read_data_o !== 32'h11BB33DD) begin
      bad++;
      $display("FAIL fwd_data got=%h want=11bb33dd", read_data_o);
    end
    do_read(2'd1, 8'd9, v, d);
    total++;
    if (d !== 32'h11BB33DD) begin
      bad++;
      $display("FAIL fwd_stored got=%h want=11bb33dd", d);
    end
  endtask

  task automatic test_refill();
    logic v;
    logic [31:0] d;
    int pulses = 0;
    fill_start_i = 1'b1;
    fill_address_i = 8'd3;
    tick();
    fill_start_i = 1'b0;
    total++;
    if (busy_o !== 1'b1) begin
      bad++;
      $display("FAIL fill_busy got=%b want=1", busy_o);
    end
    beat(32'hA0);
    pulses += int'(fill_done_o);
    beat(32'hA1);
    pulses += int'(fill_done_o);
    tick();
    pulses += int'(fill_done_o);
    beat(32'hA2);
    pulses += int'(fill_done_o);
    beat(32'hA3);
    total += 2;
    if (fill_done_o !== 1'b1) begin
      bad++;
      $display("FAIL fill_done got=%b want=1", fill_done_o);
    end
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL fill_idle got=%b want=0", busy_o);
    end
    pulses += int'(fill_done_o);
    tick();
    pulses += int'(fill_done_o);
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL fill_pulses got=%0d want=1", pulses);
    end
    for (int b = 0; b < 4; b++) begin
      do_read(2'(b), 8'd3, v, d);
      total++;
      if (v !== 1'b1 || d !== 32'hA0 + 32'(b)) begin
        bad++;
        $display("FAIL fill_rd%0d got=%b/%h want=1/%h", b, v, d, 32'hA0 + 32'(b));
      end
    end
  endtask

  task automatic test_blocking();
    logic v;
    logic [31:0] d;
    do_write(2'd0, 8'd7, 4'hF, 32'h77770000);
    fill_start_i = 1'b1;
    fill_address_i = 8'd8;
    tick();
    fill_start_i = 1'b0;
    write_i = 1'b1;
    write_bank_i = 2'd0;
    write_address_i = 8'd7;
    byte_write_i = 4'hF;
    write_data_i = 32'h0BAD0BAD;
    read_i = 1'b1;
    read_bank_i = 2'd0;
    read_address_i = 8'd7;
    tick();
    write_i = 1'b0;
    read_i = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      total++;
      if (read_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL blk_valid got=%b want=0", read_valid_o);
      end
      tick();
    end
    beat(32'hB0);
    beat(32'hB1);
    beat(32'hB2);
    beat(32'hB3);
    total++;
    if (fill_done_o !== 1'b1) begin
      bad++;
      $display("FAIL blk_done got=%b want=1", fill_done_o);
    end
    do_read(2'd0, 8'd7, v, d);
    total++;
    if (d !== 32'h77770000) begin
      bad++;
      $display("FAIL blk_keep got=%h want=77770000", d);
    end
    do_read(2'd2, 8'd8, v, d);
    total++;
    if (d !== 32'hB2) begin
      bad++;
      $display("FAIL blk_line got=%h want=000000b2", d);
    end
  endtask

  task automatic test_reset_midfill();
    logic v;
    logic [31:0] d;
    fill_start_i = 1'b1;
    fill_address_i = 8'd10;
    tick();
    fill_start_i = 1'b0;
    beat(32'hC0);
    beat(32'hC1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    total += 2;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL mid_busy got=%b want=0", busy_o);
    end
    if (fill_done_o !== 1'b0) begin
      bad++;
      $display("FAIL mid_done got=%b want=0", fill_done_o);
    end
    tick();
    total++;
    if (fill_done_o !== 1'b0) begin
      bad++;
      $display("FAIL mid_nodone got=%b want=0", fill_done_o);
    end
    fill_start_i = 1'b1;
    tick();
    fill_start_i = 1'b0;
    total++;
    if (busy_o !== 1'b1) begin
      bad++;
      $display("FAIL mid_restart got=%b want=1", busy_o);
    end
    beat(32'hD0);
    beat(32'hD1);
    beat(32'hD2);
    beat(32'hD3);
    total++;
    if (fill_done_o !== 1'b1) begin
      bad++;
      $display("FAIL mid_done2 got=%b want=1", fill_done_o);
    end
    do_read(2'd1, 8'd10, v, d);
    total++;
    if (d !== 32'hD1) begin
      bad++;
      $display("FAIL mid_rd got=%h want=000000d1", d);
    end
  endtask

  task automatic test_start_with_access();
    logic v;
    logic [31:0] d;
    fill_start_i = 1'b1;
    fill_address_i = 8'd12;
    write_i = 1'b1;
    write_bank_i = 2'd3;
    write_address_i = 8'd20;
    byte_write_i = 4'hF;
    write_data_i = 32'h12345678;
    tick();
    fill_start_i = 1'b0;
    write_i = 1'b0;
    total++;
    if (busy_o !== 1'b1) begin
      bad++;
      $display("FAIL sta_busy got=%b want=1", busy_o);
    end
    beat(32'hE0);
    beat(32'hE1);
    beat(32'hE2);
    beat(32'hE3);
    do_read(2'd3, 8'd20, v, d);
    total++;
    if (v !== 1'b1 || d !== 32'h12345678) begin
      bad++;
      $display("FAIL sta_wr got=%b/%h want=1/12345678", v, d);
    end
    do_read(2'd0, 8'd12, v, d);
    total++;
    if (d !== 32'hE0) begin
      bad++;
      $display("FAIL sta_line got=%h want=000000e0", d);
    end
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_forward();
    test_refill();
    test_blocking();
    test_reset_midfill();
    test_start_with_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
